// File: rtl/sdrc_bank_req_rsp.sv
// Bank-side chunk queue: buffers requester chunks, classifies the head as
// row hit / activate / precharge+activate, and quiesces the queue for refresh.
module sdrc_bank_req_rsp #(
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r2b_req,
  input  logic                r2b_start,
  input  logic                r2b_last,
  input  logic                r2b_wrap,
  input  logic                r2b_write,
  input  logic [REQ_ID_W-1:0] r2b_req_id,
  input  logic [1:0]          r2b_ba,
  input  logic [11:0]         r2b_raddr,
  input  logic [11:0]         r2b_caddr,
  input  logic [APP_RW-1:0]   r2b_len,
  output logic                b2r_ack,
  output logic                b2r_arb_ok,
  output logic                b2x_req,
  output logic [1:0]          b2x_cmd,
  output logic [1:0]          b2x_ba,
  output logic [11:0]         b2x_raddr,
  output logic [11:0]         b2x_caddr,
  output logic [APP_RW-1:0]   b2x_len,
  output logic [REQ_ID_W-1:0] b2x_id,
  output logic                b2x_write,
  output logic                b2x_start,
  output logic                b2x_last,
  output logic                b2x_wrap,
  input  logic                x2b_ack,
  input  logic                x2b_rf_req,
  input  logic                x2b_rf_done,
  output logic                b2x_rf_go
);

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [1:0]          ba;
    logic [11:0]         raddr;
    logic [11:0]         caddr;
    logic [APP_RW-1:0]   len;
    logic                write;
    logic                start;
    logic                last;
    logic                wrap;
  } chunk_t;

  typedef enum logic [1:0] {IDLE, DRAIN, RF} state_t;

  state_t     state;
  chunk_t     fifo [4];
  chunk_t     head;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_nxt;
  logic [3:0] bank_vld;
  logic [11:0] bank_row [4];
  logic       push, pop;

  assign b2r_ack   = r2b_req && (count < 3'd4) && (state == IDLE);
  assign push      = b2r_ack;
  assign b2x_req   = (count != 3'd0);
  assign pop       = b2x_req && x2b_ack;
  assign count_nxt = count + {2'b00, push} - {2'b00, pop};

  assign head      = fifo[rd_ptr];
  assign b2x_ba    = head.ba;
  assign b2x_raddr = head.raddr;
  assign b2x_caddr = head.caddr;
  assign b2x_len   = head.len;
  assign b2x_id    = head.id;
  assign b2x_write = head.write;
  assign b2x_start = head.start;
  assign b2x_last  = head.last;
  assign b2x_wrap  = head.wrap;

  always_comb begin
    b2x_cmd = 2'b10;
    if (!bank_vld[head.ba])                     b2x_cmd = 2'b01;
    else if (bank_row[head.ba] == head.raddr)   b2x_cmd = 2'b00;
  end

  // Payload storage and open-row table carry no reset; validity lives in count/bank_vld.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{id: r2b_req_id, ba: r2b_ba, raddr: r2b_raddr,
                               caddr: r2b_caddr, len: r2b_len, write: r2b_write,
                               start: r2b_start, last: r2b_last, wrap: r2b_wrap};
    if (pop)  bank_row[head.ba] <= head.raddr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 3'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      bank_vld   <= 4'b0;
      state      <= IDLE;
      b2r_arb_ok <= 1'b0;
      b2x_rf_go  <= 1'b0;
    end else begin
      count      <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (pop)  bank_vld[head.ba] <= 1'b1;
      b2r_arb_ok <= (state == IDLE) && !x2b_rf_req && (count_nxt <= 3'd2);
      case (state)
        IDLE:  if (x2b_rf_req) state <= DRAIN;
        DRAIN: if (count == 3'd0) begin
                 state     <= RF;
                 b2x_rf_go <= 1'b1;
               end
        // Refresh closes every row; the queue is empty here so no pop competes.
        RF:    if (x2b_rf_done) begin
                 state     <= IDLE;
                 b2x_rf_go <= 1'b0;
                 bank_vld  <= 4'b0;
               end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_bank_req_rsp.sv
// Directed bench for sdrc_bank_req_rsp: queueing, row classification, full, refresh, reset.
module tb_sdrc_bank_req_rsp;
  localparam int APP_RW = 9, REQ_ID_W = 4;

  logic clk = 1'b0, reset;
  logic r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write;
  logic [REQ_ID_W-1:0] r2b_req_id;
  logic [1:0] r2b_ba;
  logic [11:0] r2b_raddr, r2b_caddr;
  logic [APP_RW-1:0] r2b_len;
  logic b2r_ack, b2r_arb_ok, b2x_req;
  logic [1:0] b2x_cmd, b2x_ba;
  logic [11:0] b2x_raddr, b2x_caddr;
  logic [APP_RW-1:0] b2x_len;
  logic [REQ_ID_W-1:0] b2x_id;
  logic b2x_write, b2x_start, b2x_last, b2x_wrap;
  logic x2b_ack, x2b_rf_req, x2b_rf_done, b2x_rf_go;

  int errors = 0, checks = 0;

  sdrc_bank_req_rsp #(.APP_RW(APP_RW), .REQ_ID_W(REQ_ID_W)) dut (
    .clk(clk), .reset(reset),
    .r2b_req(r2b_req), .r2b_start(r2b_start), .r2b_last(r2b_last), .r2b_wrap(r2b_wrap),
    .r2b_write(r2b_write), .r2b_req_id(r2b_req_id), .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr),
    .r2b_caddr(r2b_caddr), .r2b_len(r2b_len), .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok),
    .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_ba(b2x_ba), .b2x_raddr(b2x_raddr),
    .b2x_caddr(b2x_caddr), .b2x_len(b2x_len), .b2x_id(b2x_id), .b2x_write(b2x_write),
    .b2x_start(b2x_start), .b2x_last(b2x_last), .b2x_wrap(b2x_wrap), .x2b_ack(x2b_ack),
    .x2b_rf_req(x2b_rf_req), .x2b_rf_done(x2b_rf_done), .b2x_rf_go(b2x_rf_go)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic [1:0] ba, input logic [11:0] raddr);
    r2b_req = 1'b1; r2b_ba = ba; r2b_raddr = raddr; r2b_caddr = raddr + 12'h001;
    r2b_len = 9'd8; r2b_req_id = raddr[3:0]; r2b_write = raddr[0];
    r2b_start = 1'b1; r2b_last = 1'b1; r2b_wrap = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; r2b_req = 1'b0; x2b_ack = 1'b0; x2b_rf_req = 1'b0; x2b_rf_done = 1'b0;
    drive_req(2'd0, 12'h000); r2b_req = 1'b0;
    #2;
    checks++; if (b2x_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", b2x_req); end
    checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", b2r_ack); end
    checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL rst_arb got %b want 0", b2r_arb_ok); end
    checks++; if (b2x_rf_go !== 1'b0) begin errors++; $display("FAIL rst_rfgo got %b want 0", b2x_rf_go); end
    tick; tick; reset = 1'b0; #1;
    checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL rel_arb0 got %b want 0", b2r_arb_ok); end
    tick;
    checks++; if (b2r_arb_ok !== 1'b1) begin errors++; $display("FAIL rel_arb1 got %b want 1", b2r_arb_ok); end
  endtask

  task automatic test_hit_miss;
    drive_req(2'd1, 12'h010); #1;
    checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL hm_ack got %b want 1", b2r_ack); end
    tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_req !== 1'b1) begin errors++; $display("FAIL hm_req got %b want 1", b2x_req); end
    checks++; if (b2x_cmd !== 2'b01) begin errors++; $display("FAIL hm_cmd_act got %b want 01", b2x_cmd); end
    checks++; if ({b2x_ba, b2x_raddr, b2x_caddr} !== {2'd1, 12'h010, 12'h011})
      begin errors++; $display("FAIL hm_addr got %h/%h/%h want 1/010/011", b2x_ba, b2x_raddr, b2x_caddr); end
    checks++; if ({b2x_len, b2x_id, b2x_write, b2x_start, b2x_last, b2x_wrap} !== {9'd8, 4'h0, 4'b0110})
      begin errors++; $display("FAIL hm_fields got len=%0d id=%h w=%b s=%b l=%b wr=%b", b2x_len, b2x_id, b2x_write, b2x_start, b2x_last, b2x_wrap); end
    x2b_ack = 1'b1; tick;
    tick; x2b_ack = 1'b0; #1;   // extra ack while empty must be ignored
    checks++; if (b2x_req !== 1'b0) begin errors++; $display("FAIL hm_empty got %b want 0", b2x_req); end
    drive_req(2'd1, 12'h010); tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_cmd !== 2'b00) begin errors++; $display("FAIL hm_cmd_hit got %b want 00", b2x_cmd); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
  endtask

  task automatic test_row_miss;
    drive_req(2'd2, 12'h005); tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_cmd !== 2'b01) begin errors++; $display("FAIL rm_act got %b want 01", b2x_cmd); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
    drive_req(2'd2, 12'h006); tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_cmd !== 2'b10) begin errors++; $display("FAIL rm_pre got %b want 10", b2x_cmd); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
    drive_req(2'd2, 12'h006); tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_cmd !== 2'b00) begin errors++; $display("FAIL rm_newrow got %b want 00", b2x_cmd); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
    drive_req(2'd1, 12'h010); tick; r2b_req = 1'b0; #1;
    checks++; if (b2x_cmd !== 2'b00) begin errors++; $display("FAIL rm_other got %b want 00", b2x_cmd); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
  endtask

  task automatic test_full;
    int nacks = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(2'd3, 12'h100 + 12'(nacks)); #1;
      if (b2r_ack) nacks++;
      tick;
    end
    #1;
    checks++; if (nacks !== 4) begin errors++; $display("FAIL full_acks got %0d want 4", nacks); end
    checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL full_ack got %b want 0", b2r_ack); end
    checks++; if (b2r_arb_ok !== 1'b0) begin errors++; $display("FAIL full_arb got %b want 0", b2r_arb_ok); end
    checks++; if (b2x_raddr !== 12'h100) begin errors++; $display("FAIL full_head0 got %h want 100", b2x_raddr); end
    r2b_req = 1'b0; x2b_ack = 1'b1; tick; x2b_ack = 1'b0; #1;
    checks++; if ({b2x_raddr, b2x_cmd} !== {12'h101, 2'b10}) begin errors++; $display("FAIL full_head1 got %h/%b want 101/10", b2x_raddr, b2x_cmd); end
    drive_req(2'd3, 12'h104); x2b_ack = 1'b1; #1;
    checks++; if (b2r_ack !== 1'b1) begin errors++; $display("FAIL full_pp_ack got %b want 1", b2r_ack); end
    tick;
    drive_req(2'd3, 12'h105); x2b_ack = 1'b0; #1;
    checks++; if ({b2r_ack, b2x_raddr} !== {1'b1, 12'h102}) begin errors++; $display("FAIL full_pp got ack=%b head=%h want 1/102", b2r_ack, b2x_raddr); end
    tick; #1;
    checks++; if (b2r_ack !== 1'b0) begin errors++; $display("FAIL full_refill got %b want 0", b2r_ack); end
    r2b_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b2x_raddr !== 12'h102 + 12'(i)) begin errors++; $display("FAIL full_order%0d got %h want %h", i, b2x_raddr, 12'h102 + 12'(i)); end
      x2b_ack = 1'b1; tick;
    end
    x2b_ack = 1'b0; #1;
    checks++; if ({b2x_req, b2r_arb_ok} !== 2'b01) begin errors++; $display("FAIL full_drained got req=%b arb=%b want 0/1", b2x_req, b2r_arb_ok); end
  endtask

  task automatic test_refresh;
    drive_req(2'd0, 12'h020); tick;
    drive_req(2'd1, 12'h030); tick;
    r2b_req = 1'b0; x2b_rf_req = 1'b1; tick;
    x2b_rf_req = 1'b0; x2b_rf_done = 1'b1; drive_req(2'd0, 12'h040); #1;
    checks++; if ({b2r_ack, b2x_req, b2r_arb_ok, b2x_rf_go} !== 4'b0100)
      begin errors++; $display("FAIL rf_drain got ack=%b req=%b arb=%b go=%b want 0/1/0/0", b2r_ack, b2x_req, b2r_arb_ok, b2x_rf_go); end
    checks++; if (b2x_raddr !== 12'h020) begin errors++; $display("FAIL rf_head0 got %h want 020", b2x_raddr); end
    x2b_ack = 1'b1; tick; x2b_rf_done = 1'b0; #1;
    checks++; if ({b2r_ack, b2x_raddr, b2x_cmd} !== {1'b0, 12'h030, 2'b10})
      begin errors++; $display("FAIL rf_head1 got ack=%b %h/%b want 0/030/10", b2r_ack, b2x_raddr, b2x_cmd); end
    tick; x2b_ack = 1'b0; #1;
    checks++; if ({b2x_req, b2x_rf_go} !== 2'b00) begin errors++; $display("FAIL rf_empty got req=%b go=%b want 0/0", b2x_req, b2x_rf_go); end
    tick;
    checks++; if ({b2x_rf_go, b2r_ack} !== 2'b10) begin errors++; $display("FAIL rf_go got go=%b ack=%b want 1/0", b2x_rf_go, b2r_ack); end
    x2b_rf_done = 1'b1; tick; x2b_rf_done = 1'b0; #1;
    checks++; if ({b2x_rf_go, b2r_ack} !== 2'b01) begin errors++; $display("FAIL rf_done got go=%b ack=%b want 0/1", b2x_rf_go, b2r_ack); end
    tick; r2b_req = 1'b0; #1;
    checks++; if ({b2x_raddr, b2x_cmd, b2r_arb_ok} !== {12'h040, 2'b01, 1'b1})
      begin errors++; $display("FAIL rf_closed got %h/%b arb=%b want 040/01/1", b2x_raddr, b2x_cmd, b2r_arb_ok); end
    x2b_ack = 1'b1; tick; x2b_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin drive_req(2'd0, 12'h200 + 12'(i)); tick; end
    r2b_req = 1'b0; x2b_rf_req = 1'b1; tick;
    #2 reset = 1'b1; #1;
    checks++; if ({b2x_req, b2r_ack, b2r_arb_ok, b2x_rf_go} !== 4'b0000)
      begin errors++; $display("FAIL mid_rst got req=%b ack=%b arb=%b go=%b want 0000", b2x_req, b2r_ack, b2r_arb_ok, b2x_rf_go); end
    tick; reset = 1'b0;
    tick; tick; #1;
    checks++; if ({b2x_rf_go, b2x_req} !== 2'b10) begin errors++; $display("FAIL mid_rf got go=%b req=%b want 1/0", b2x_rf_go, b2x_req); end
    #2 reset = 1'b1; #1;
    checks++; if (b2x_rf_go !== 1'b0) begin errors++; $display("FAIL rf_rst got %b want 0", b2x_rf_go); end
    x2b_rf_req = 1'b0; tick; reset = 1'b0; tick; #1;
    checks++; if ({b2x_req, b2r_arb_ok} !== 2'b01) begin errors++; $display("FAIL post_rst got req=%b arb=%b want 0/1", b2x_req, b2r_arb_ok); end
  endtask

  initial begin
    test_reset;
    test_hit_miss;
    test_row_miss;
    test_full;
    test_refresh;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
